key_loader: RTL and testbench

Serial key-entry front end for the locked blink datapath. It receives a key frame over a 3-wire serial link from the board header or the test harness: chip-select, serial clock and serial data, all asynchronous to `clk`. It checks the frame's parity and drives the parallel `key` bus consumed directly by the downstream blinker. The key is fail-safe: it is all-zero after reset and after any bad frame.

---
 rtl/key_loader_pkg.sv | 15 +
 rtl/sync_edge.sv | 39 +++
 rtl/key_loader.sv | 110 +++++++++++
 tb/tb_key_loader.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_loader_pkg.sv
// rtl/key_loader_pkg.sv - shared types and helpers for the serial key loader
package key_loader_pkg;

  typedef enum logic [2:0] {IDLE, SHIFT, CHECK, ERROR, WAIT_CS} state_t;

  function automatic int frame_len(input int key_w);
    return key_w + 1;
  endfunction

  // Odd parity over data plus parity bit; callers zero-extend, which leaves the XOR unchanged.
  function automatic logic odd_parity_ok(input logic [63:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - N-flop synchronizer with optional registered rising-edge strobe
module sync_edge #(
  parameter int STAGES = 2,
  parameter bit EDGE   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (rst) chain <= '0;
    else     chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

  if (EDGE) begin : g_edge
    logic prev;
    logic rise_r;
    always_ff @(posedge clk) begin
      if (rst) begin
        prev   <= 1'b0;
        rise_r <= 1'b0;
      end else begin
        prev   <= q;
        rise_r <= q & ~prev;
      end
    end
    assign rise = rise_r;
  end else begin : g_level
    assign rise = 1'b0;
  end

endmodule

// File: rtl/key_loader.sv
// rtl/key_loader.sv - serial key frame receiver with odd-parity check and fail-safe key output
module key_loader
  import key_loader_pkg::*;
#(
  parameter int KEY_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ser_cs_n,
  input  logic             ser_clk,
  input  logic             ser_data,
  output logic [KEY_W-1:0] key,
  output logic             key_valid,
  output logic             key_err,
  output logic             busy
);

  localparam int FRAME  = frame_len(KEY_W);
  localparam int BCNT_W = $clog2(KEY_W + 2);
  localparam int TCNT_W = $clog2(TIMEOUT + 1);

  logic cs_n_s, data_s, bit_strobe;
  logic cs_rise_unused, data_rise_unused;

  sync_edge #(.STAGES(SYNC_STAGES), .EDGE(1'b1)) u_sync_clk (
    .clk(clk), .rst(rst), .d(ser_clk), .q(), .rise(bit_strobe)
  );
  sync_edge #(.STAGES(SYNC_STAGES), .EDGE(1'b0)) u_sync_cs (
    .clk(clk), .rst(rst), .d(ser_cs_n), .q(cs_n_s), .rise(cs_rise_unused)
  );
  sync_edge #(.STAGES(SYNC_STAGES), .EDGE(1'b0)) u_sync_data (
    .clk(clk), .rst(rst), .d(ser_data), .q(data_s), .rise(data_rise_unused)
  );

  state_t            state, state_next;
  logic [FRAME-1:0]  shreg;
  logic [BCNT_W-1:0] bcnt;
  logic [TCNT_W-1:0] tcnt, tcnt_inc;
  logic              armed;
  logic              last_bit, parity_ok;

  assign tcnt_inc  = tcnt + TCNT_W'(1);
  assign last_bit  = bit_strobe && (bcnt == BCNT_W'(KEY_W));
  assign parity_ok = odd_parity_ok(64'(shreg));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // armed blocks a frame whose cs_n was already low across a reset from being accepted.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (!cs_n_s && armed) state_next = SHIFT;
      SHIFT: begin
        if (last_bit)                                             state_next = CHECK;
        else if (cs_n_s)                                          state_next = ERROR;
        else if (!bit_strobe && (tcnt_inc == TCNT_W'(TIMEOUT)))   state_next = ERROR;
      end
      CHECK:   state_next = parity_ok ? WAIT_CS : ERROR;
      ERROR:   state_next = WAIT_CS;
      WAIT_CS: if (cs_n_s) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg     <= '0;
      bcnt      <= '0;
      tcnt      <= '0;
      armed     <= 1'b0;
      key       <= '0;
      key_valid <= 1'b0;
      key_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      busy <= (state_next == SHIFT) || (state_next == CHECK);
      if (cs_n_s) armed <= 1'b1;
      case (state)
        IDLE: if (state_next == SHIFT) begin
          bcnt    <= '0;
          tcnt    <= '0;
          key_err <= 1'b0;
        end
        SHIFT: if (bit_strobe) begin
          shreg <= {shreg[FRAME-2:0], data_s};
          bcnt  <= bcnt + BCNT_W'(1);
          tcnt  <= '0;
        end else begin
          tcnt  <= tcnt_inc;
        end
        CHECK: if (parity_ok) begin
          key       <= shreg[FRAME-1:1];
          key_valid <= 1'b1;
        end
        ERROR: begin
          key       <= '0;
          key_valid <= 1'b0;
          key_err   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_key_loader.sv
// tb/tb_key_loader.sv - randomized and directed bench for key_loader against a frame-level model
module tb_key_loader;

  localparam int SS  = 2;
  localparam int TMO = 16;

  logic       clk, rst, ser_cs_n, ser_clk, ser_data;
  logic [7:0] key;
  logic       key_valid, key_err, busy;

  key_loader #(.KEY_W(8), .SYNC_STAGES(SS), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .ser_cs_n(ser_cs_n), .ser_clk(ser_clk), .ser_data(ser_data),
    .key(key), .key_valid(key_valid), .key_err(key_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_rise = 0;
  int last_rst = 0;

  // Pin samples indexed by the clock edge that captured them.
  bit hc[$];
  bit hs[$];
  bit hd[$];
  initial begin
    hc.push_back(1'b0);
    hs.push_back(1'b0);
    hd.push_back(1'b0);
  end

  logic [7:0] m_key;
  bit         m_valid, m_err, m_busy, m_ok;
  bit         in_frame, waiting, armed;
  int         nbits, idle, apply_at, check_edge;
  logic [8:0] sh;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic bit hv(input int which, input int k);
    if (k < 1 || k <= last_rst) return 1'b0;
    case (which)
      0:       return hc[k];
      1:       return hs[k];
      default: return hd[k];
    endcase
  endfunction

  task automatic fail_frame();
    in_frame = 0;
    waiting  = 1;
    m_ok     = 0;
    apply_at = cyc + 1;
  endtask

  // Frame-level reference: pins reach the decision logic SS cycles late, strobes one cycle later still.
  always @(posedge clk) begin
    bit cs, str, d;
    cyc++;
    hc.push_back(ser_clk);
    hs.push_back(ser_cs_n);
    hd.push_back(ser_data);
    if (rst) begin
      last_rst = cyc;
      m_key = 8'h00; m_valid = 0; m_err = 0;
      in_frame = 0; waiting = 0; armed = 0;
      apply_at = -1; check_edge = -1;
    end else begin
      cs  = hv(1, cyc - SS);
      d   = hv(2, cyc - SS);
      str = hv(0, cyc - SS - 1) && !hv(0, cyc - SS - 2);
      if (apply_at == cyc) begin
        if (m_ok) begin m_key = sh[8:1]; m_valid = 1; end
        else begin m_key = 8'h00; m_valid = 0; m_err = 1; end
      end else if (in_frame) begin
        if (str && nbits == 8) begin
          sh = {sh[7:0], d};
          in_frame = 0; waiting = 1; check_edge = cyc;
          m_ok = ($countones(sh) % 2) == 1;
          apply_at = m_ok ? cyc + 1 : cyc + 2;
        end else if (cs) begin
          fail_frame();
        end else if (str) begin
          sh = {sh[7:0], d}; nbits++; idle = 0;
        end else begin
          idle++;
          if (idle == TMO) fail_frame();
        end
      end else if (waiting) begin
        if (cyc > apply_at && cs) waiting = 0;
      end else if (armed && !cs) begin
        in_frame = 1; nbits = 0; idle = 0; m_err = 0;
      end
      if (cs) armed = 1;
    end
    m_busy = in_frame || (cyc == check_edge);
  end

  always @(negedge clk) begin
    if (cyc >= 1) begin
      chk("key", key, m_key);
      chk("key_valid", key_valid, m_valid);
      chk("key_err", key_err, m_err);
      chk("busy", busy, m_busy);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic bit_rise(input bit b, input int half);
    ser_data = b;
    cycles(half);
    ser_clk = 1'b1;
    last_rise = cyc + 1;
  endtask

  task automatic bit_fall(input int half);
    cycles(half);
    ser_clk = 1'b0;
  endtask

  task automatic send_bit(input bit b, input int half);
    bit_rise(b, half);
    bit_fall(half);
  endtask

  task automatic send_bits(input logic [8:0] v, input int first, input int n, input int half);
    for (int i = first; i > first - n; i--) send_bit(v[i], half);
  endtask

  task automatic cs_low();
    ser_cs_n = 1'b0;
    cycles(2);
  endtask

  task automatic cs_high();
    cycles(2);
    ser_cs_n = 1'b1;
    cycles(6);
  endtask

  task automatic chk_out(input string name, input logic [7:0] k, input bit v, input bit e);
    chk({name, "_key"}, key, k);
    chk({name, "_valid"}, key_valid, v);
    chk({name, "_err"}, key_err, e);
  endtask

  initial begin
    logic [8:0] fr;
    rst = 1'b1; ser_cs_n = 1'b1; ser_clk = 1'b0; ser_data = 1'b0;
    cycles(3);
    rst = 1'b0;
    cycles(1);
    chk_out("reset", 8'h00, 0, 0);
    chk("reset_busy", busy, 0);
    cycles(4);

    // Good 0xA5: key appears exactly two cycles after the final strobe.
    cs_low();
    send_bits({8'hA5, 1'b1}, 8, 8, 4);
    bit_rise(1'b1, 4);
    wait_until(last_rise + 3);
    chk("a5_hold_valid", key_valid, 0);
    chk("a5_check_busy", busy, 1);
    wait_until(last_rise + 4);
    chk_out("a5_load", 8'hA5, 1, 0);
    chk("model_a5", m_key, 8'hA5);
    bit_fall(4);
    send_bit(1'b0, 4);
    send_bit(1'b1, 4);
    chk("a5_extra_ignored", key, 8'hA5);
    cs_high();

    // Bad parity on 0xA5, with trailing pulses ignored.
    cs_low();
    send_bits({8'hA5, 1'b0}, 8, 9, 4);
    send_bits(9'h1FF, 8, 3, 4);
    chk_out("bad_par", 8'h00, 0, 1);
    cs_high();
    cs_low();
    bit_rise(1'b0, 4);
    chk("err_clear_at_start", key_err, 0);
    bit_fall(4);
    send_bits({8'h3C, 1'b1}, 7, 8, 4);
    cycles(3);
    chk_out("c3_load", 8'h3C, 1, 0);
    cs_high();

    // Stall after three bits with TIMEOUT=16.
    cs_low();
    send_bits({8'hF0, 1'b0}, 8, 3, 4);
    wait_until(last_rise + 18);
    chk("tmo_busy", busy, 1);
    wait_until(last_rise + 19);
    chk_out("tmo_pre", 8'h3C, 1, 0);
    wait_until(last_rise + 20);
    chk_out("tmo_err", 8'h00, 0, 1);
    send_bits(9'h1FF, 8, 2, 4);
    cs_high();

    // Early cs_n rise after four bits.
    cs_low();
    send_bits({8'hA5, 1'b1}, 8, 4, 4);
    cs_high();
    chk_out("early_cs", 8'h00, 0, 1);

    // Back-to-back frames; second ends with cs_n rising alongside the final strobe.
    cs_low();
    send_bits({8'hA5, 1'b1}, 8, 9, 4);
    cs_high();
    cs_low();
    send_bits({8'h3C, 1'b1}, 8, 4, 4);
    chk_out("b2b_hold", 8'hA5, 1, 0);
    chk("b2b_busy", busy, 1);
    send_bits({8'h3C, 1'b1}, 4, 4, 4);
    bit_rise(1'b1, 4);
    cycles(1);
    ser_cs_n = 1'b1;
    wait_until(last_rise + 4);
    chk_out("coincident_cs", 8'h3C, 1, 0);
    bit_fall(4);
    cycles(6);

    // Reset mid-frame, then the rest of that frame must not load.
    cs_low();
    send_bits({8'hC3, 1'b1}, 8, 5, 4);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    chk_out("mid_rst", 8'h00, 0, 0);
    chk("mid_rst_busy", busy, 0);
    send_bits({8'hC3, 1'b1}, 3, 4, 4);
    cs_high();
    chk_out("stale_frame", 8'h00, 0, 0);
    cs_low();
    send_bits({8'h5A, 1'b1}, 8, 9, 4);
    cycles(3);
    chk_out("fresh_5a", 8'h5A, 1, 0);
    cs_high();

    // Randomized frames: good, bad parity, early cs_n, stall, trailing pulses.
    for (int it = 0; it < 40; it++) begin
      logic [7:0] dat;
      int half, kind, nb;
      dat  = 8'($urandom);
      half = $urandom_range(4, 6);
      kind = $urandom_range(0, 5);
      nb   = $urandom_range(0, 8);
      fr   = {dat, ~^dat};
      ser_cs_n = 1'b0;
      cycles($urandom_range(1, 4));
      case (kind)
        0, 1: send_bits(fr, 8, 9, half);
        2: send_bits({dat, ^dat}, 8, 9, half);
        3: begin send_bits(fr, 8, nb, half); cycles($urandom_range(0, 3)); end
        4: begin send_bits(fr, 8, nb, half); cycles(TMO + 6); send_bits(9'h155, 8, 2, half); end
        default: begin send_bits(fr, 8, 9, half); send_bits(9'h0AA, 8, 2, half); end
      endcase
      cycles($urandom_range(0, 5));
      ser_cs_n = 1'b1;
      cycles($urandom_range(5, 9));
    end

    cycles(10);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
